// File: rtl/frame_sync_ctrl_if.sv
// Serial receive / payload bus for frame_sync_ctrl.
//   x, bit_valid, resync     : from the receive front end into the controller
//   sync_state, locked       : sync status from the controller
//   frame_start, miss_err    : one-cycle event pulses from the controller
//   payload_valid/bit        : gated payload stream from the controller
// master = front end / consumer side, slave = controller side.
interface frame_sync_ctrl_if;
    logic       x;
    logic       bit_valid;
    logic       resync;
    logic [1:0] sync_state;
    logic       locked;
    logic       frame_start;
    logic       miss_err;
    logic       payload_valid;
    logic       payload_bit;

    modport master (
        output x, bit_valid, resync,
        input  sync_state, locked, frame_start, miss_err, payload_valid, payload_bit
    );

    modport slave (
        input  x, bit_valid, resync,
        output sync_state, locked, frame_start, miss_err, payload_valid, payload_bit
    );
endinterface

// File: rtl/frame_sync_ctrl.sv
// Frame synchronisation controller for a serial stream framed by the
// preamble 101010. Hunts for the preamble, verifies it recurs every
// FRAME_LEN+6 bits, locks, flywheels through isolated misses and drops
// lock after UNLOCK_CNT consecutive misses. Payload bits pass only while
// locked.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : frame_sync_ctrl_if.slave (serial input, status, pulses, payload)
module frame_sync_ctrl #(
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned LOCK_CNT   = 2,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic                clk,
    input  logic                rst,
    frame_sync_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam int unsigned POS_W  = $clog2(FRAME_LEN + 6);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [POS_W-1:0]  POS_PAY_END = POS_W'(FRAME_LEN);
    localparam logic [POS_W-1:0]  POS_WIN_END = POS_W'(FRAME_LEN + 5);
    localparam logic [GOOD_W-1:0] GOOD_LOCK   = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE    = GOOD_W'(1);
    localparam logic [MISS_W-1:0] MISS_MAX    = MISS_W'(UNLOCK_CNT);
    localparam logic [5:0]        PREAMBLE    = 6'b101010;

    state_t              state_q, state_d;
    logic [4:0]          sr_q, sr_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [MISS_W-1:0]   misses_q, misses_d;
    logic                locked_q, locked_d;
    logic                frame_start_q, frame_start_d;
    logic                miss_err_q, miss_err_d;
    logic                payload_valid_q, payload_valid_d;
    logic                payload_bit_q, payload_bit_d;

    logic                match_c;
    logic [GOOD_W-1:0]   good_inc_c;
    logic [MISS_W-1:0]   misses_inc_c;

    assign match_c      = ({sr_q, bus.x} == PREAMBLE);
    assign good_inc_c   = good_q + GOOD_W'(1);
    assign misses_inc_c = misses_q + MISS_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_HUNT;
            sr_q            <= '0;
            pos_q           <= '0;
            good_q          <= '0;
            misses_q        <= '0;
            locked_q        <= 1'b0;
            frame_start_q   <= 1'b0;
            miss_err_q      <= 1'b0;
            payload_valid_q <= 1'b0;
            payload_bit_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            sr_q            <= sr_d;
            pos_q           <= pos_d;
            good_q          <= good_d;
            misses_q        <= misses_d;
            locked_q        <= locked_d;
            frame_start_q   <= frame_start_d;
            miss_err_q      <= miss_err_d;
            payload_valid_q <= payload_valid_d;
            payload_bit_q   <= payload_bit_d;
        end
    end

    // Next-state, counters and pulse generation
    always_comb begin
        state_d         = state_q;
        sr_d            = sr_q;
        pos_d           = pos_q;
        good_d          = good_q;
        misses_d        = misses_q;
        frame_start_d   = 1'b0;
        miss_err_d      = 1'b0;
        payload_valid_d = 1'b0;
        payload_bit_d   = payload_bit_q;

        if (bus.resync) begin
            // Forced restart; any bit sampled this cycle is discarded
            state_d  = ST_HUNT;
            sr_d     = '0;
            pos_d    = '0;
            good_d   = '0;
            misses_d = '0;
        end else if (bus.bit_valid) begin
            sr_d = {sr_q[3:0], bus.x};
            case (state_q)
                ST_HUNT: begin
                    if (match_c) begin
                        frame_start_d = 1'b1;
                        pos_d         = '0;
                        good_d        = GOOD_ONE;
                        misses_d      = '0;
                        state_d       = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY, ST_LOCKED: begin
                    if (pos_q != POS_WIN_END) begin
                        // Payload or inside the window: preamble not checked yet
                        pos_d = pos_q + POS_W'(1);
                        if ((state_q == ST_LOCKED) && (pos_q < POS_PAY_END)) begin
                            payload_valid_d = 1'b1;
                            payload_bit_d   = bus.x;
                        end
                    end else begin
                        pos_d = '0;
                        if (match_c) begin
                            frame_start_d = 1'b1;
                            if (state_q == ST_VERIFY) begin
                                good_d = good_inc_c;
                                if (good_inc_c == GOOD_LOCK) begin
                                    state_d = ST_LOCKED;
                                end
                            end else begin
                                misses_d = '0;
                            end
                        end else begin
                            miss_err_d = 1'b1;
                            if (state_q == ST_VERIFY) begin
                                state_d = ST_HUNT;
                                good_d  = '0;
                            end else if (misses_inc_c == MISS_MAX) begin
                                state_d  = ST_HUNT;
                                good_d   = '0;
                                misses_d = '0;
                            end else begin
                                // Flywheel: keep lock, start next frame
                                misses_d = misses_inc_c;
                            end
                        end
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    pos_d    = '0;
                    good_d   = '0;
                    misses_d = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    assign bus.sync_state    = state_q;
    assign bus.locked        = locked_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.miss_err      = miss_err_q;
    assign bus.payload_valid = payload_valid_q;
    assign bus.payload_bit   = payload_bit_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: directed scenarios followed by
// randomized framed traffic, all compared cycle by cycle against a
// behavioural model built on a bit-history queue and frame position.
module tb_frame_sync_ctrl;

    localparam int FL  = 4;
    localparam int LCK = 2;
    localparam int ULK = 2;
    localparam int HUNT = 0, VERIFY = 1, LOCKED = 2;

    logic clk;
    logic rst;
    frame_sync_ctrl_if bus();

    frame_sync_ctrl #(.FRAME_LEN(FL), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_hist[$];
    int m_state, m_pos, m_good, m_miss;
    logic m_fs, m_me, m_pv, m_pb;

    // Observation accumulators for scenario-level checks
    int   n_fs, n_me, n_pv;
    logic [31:0] pay_word;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist  = '{0, 0, 0, 0, 0};
        m_state = HUNT;
        m_pos   = 0;
        m_good  = 0;
        m_miss  = 0;
        m_fs    = 1'b0;
        m_me    = 1'b0;
        m_pv    = 1'b0;
        m_pb    = 1'b0;
    endtask

    task automatic model_hunt();
        m_state = HUNT;
        m_pos   = 0;
        m_good  = 0;
        m_miss  = 0;
    endtask

    task automatic model_step(input logic v, input logic xb, input logic rs);
        bit match;
        m_fs = 1'b0;
        m_me = 1'b0;
        m_pv = 1'b0;
        if (rs) begin
            model_hunt();
            m_hist = '{0, 0, 0, 0, 0};
            return;
        end
        if (!v) return;
        // Last five bits (oldest first) plus the new one must read 101010
        match = (m_hist[0] == 1) && (m_hist[1] == 0) && (m_hist[2] == 1) &&
                (m_hist[3] == 0) && (m_hist[4] == 1) && (xb == 1'b0);
        m_hist.push_back(int'(xb));
        void'(m_hist.pop_front());
        if (m_state == HUNT) begin
            if (match) begin
                m_fs    = 1'b1;
                m_pos   = 0;
                m_good  = 1;
                m_miss  = 0;
                m_state = (LCK == 1) ? LOCKED : VERIFY;
            end
        end else if (m_pos < FL + 5) begin
            if (m_state == LOCKED && m_pos < FL) begin
                m_pv = 1'b1;
                m_pb = xb;
            end
            m_pos++;
        end else begin
            m_pos = 0;
            if (match) begin
                m_fs = 1'b1;
                if (m_state == VERIFY) begin
                    m_good++;
                    if (m_good >= LCK) m_state = LOCKED;
                end else begin
                    m_miss = 0;
                end
            end else begin
                m_me = 1'b1;
                if (m_state == VERIFY) model_hunt();
                else begin
                    m_miss++;
                    if (m_miss >= ULK) model_hunt();
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("sync_state", 32'(bus.sync_state), 32'(m_state));
        check_eq("locked", 32'(bus.locked), 32'(m_state == LOCKED));
        check_eq("frame_start", 32'(bus.frame_start), 32'(m_fs));
        check_eq("miss_err", 32'(bus.miss_err), 32'(m_me));
        check_eq("payload_valid", 32'(bus.payload_valid), 32'(m_pv));
        if (m_pv) check_eq("payload_bit", 32'(bus.payload_bit), 32'(m_pb));
        if (bus.frame_start) n_fs++;
        if (bus.miss_err) n_me++;
        if (bus.payload_valid) begin
            n_pv++;
            pay_word = {pay_word[30:0], bus.payload_bit};
        end
    endtask

    // One clock: drive at negedge, let the rising edge sample, check at next negedge
    task automatic step(input logic v, input logic xb, input logic rs);
        bus.bit_valid = v;
        bus.x         = xb;
        bus.resync    = rs;
        model_step(v, xb, rs);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_bits(input string s, input int gap);
        logic b;
        for (int i = 0; i < s.len(); i++) begin
            b = (s[i] == "1");
            step(1'b1, b, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, (g % 2 == 0) ? ~b : b, 1'b0);
        end
    endtask

    task automatic clear_counts();
        n_fs = 0; n_me = 0; n_pv = 0; pay_word = '0;
    endtask

    task automatic acquire(input int gap);
        clear_counts();
        send_bits("101010", gap);
        check_eq("acq_verify_state", 32'(bus.sync_state), 32'd1);
        send_bits("1100101010", gap);
        check_eq("acq_locked_state", 32'(bus.sync_state), 32'd2);
        check_eq("acq_frame_starts", 32'(n_fs), 32'd2);
        send_bits("0110", gap);
        check_eq("acq_payload_cnt", 32'(n_pv), 32'd4);
        check_eq("acq_payload_bits", pay_word, 32'h6);
    endtask

    initial begin
        string bits;
        int    n;
        logic  b;

        rst = 1'b0;
        bus.x = 1'b0; bus.bit_valid = 1'b0; bus.resync = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);
        compare_all();
        check_eq("rst_payload_bit", 32'(bus.payload_bit), 32'd0);
        rst = 1'b1;

        // Acquire lock from a clean start
        acquire(0);

        // Flywheel through a single bad window, then recover
        clear_counts();
        send_bits("101011", 0);
        check_eq("fly_miss", 32'(n_me), 32'd1);
        check_eq("fly_locked", 32'(bus.locked), 32'd1);
        send_bits("1001", 0);
        check_eq("fly_payload_cnt", 32'(n_pv), 32'd4);
        check_eq("fly_payload_bits", pay_word, 32'h9);
        send_bits("101010", 0);
        check_eq("fly_recover_fs", 32'(n_fs), 32'd1);

        // Two consecutive bad windows drop lock
        clear_counts();
        send_bits("1111000000", 0);
        check_eq("lol_still_locked", 32'(bus.locked), 32'd1);
        send_bits("0101111111", 0);
        check_eq("lol_misses", 32'(n_me), 32'd2);
        check_eq("lol_hunt", 32'(bus.sync_state), 32'd0);
        n_pv = 0;
        send_bits("0000110000", 0);
        check_eq("lol_no_payload", 32'(n_pv), 32'd0);

        // Same acquisition stretched by idle gaps
        step(1'b0, 1'b0, 1'b1);
        acquire(3);

        // resync with a valid bit while locked: bit dropped, back to hunt
        step(1'b1, 1'b1, 1'b1);
        check_eq("resync_hunt", 32'(bus.sync_state), 32'd0);

        // False preamble inside the payload is ignored
        acquire(0);
        send_bits("101010", 0);
        clear_counts();
        send_bits("1010101010", 0);
        check_eq("false_pre_fs", 32'(n_fs), 32'd1);
        check_eq("false_pre_locked", 32'(bus.locked), 32'd1);

        // Asynchronous reset mid-frame while locked
        send_bits("01", 0);
        check_eq("pre_rst_locked", 32'(bus.locked), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_state", 32'(bus.sync_state), 32'd0);
        check_eq("arst_locked", 32'(bus.locked), 32'd0);
        check_eq("arst_fs", 32'(bus.frame_start), 32'd0);
        check_eq("arst_me", 32'(bus.miss_err), 32'd0);
        check_eq("arst_pv", 32'(bus.payload_valid), 32'd0);
        check_eq("arst_pb", 32'(bus.payload_bit), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        clear_counts();
        send_bits("0000000000", 0);
        check_eq("post_rst_no_fs", 32'(n_fs), 32'd0);

        // Randomized framed traffic with corruption, slips, gaps and resyncs
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 4) != 0) bits = "101010";
            else begin
                bits = "";
                for (int i = 0; i < 6; i++) bits = {bits, ($urandom_range(0, 1) != 0) ? "1" : "0"};
            end
            for (int i = 0; i < FL; i++) bits = {bits, ($urandom_range(0, 1) != 0) ? "1" : "0"};
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) bits = {bits, ($urandom_range(0, 1) != 0) ? "1" : "0"};
            end
            for (int i = 0; i < bits.len(); i++) begin
                b = (bits[i] == "1");
                if ($urandom_range(0, 299) == 0) step(($urandom_range(0, 1) != 0), b, 1'b1);
                else step(1'b1, b, 1'b0);
                if ($urandom_range(0, 3) == 0) begin
                    n = $urandom_range(1, 2);
                    for (int g = 0; g < n; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Frame synchronisation controller for a serial bit stream framed by the 6-bit preamble 101010. It hunts for the preamble, verifies it recurs at the expected frame spacing, and declares lock. While locked it flywheels through isolated corrupted preambles and drops lock after repeated misses. It sits between the serial receive front end and the payload consumer, and it gates payload bits out only while locked.

## Interface
- FRAME_LEN, 16: payload bits between consecutive preambles (≥1).
- LOCK_CNT, 2: consecutive on-time preambles, including the first, required to reach lock (≥1).
- UNLOCK_CNT, 2: consecutive missed preamble windows that drop lock (≥1).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- bit_valid  in  1  x is sampled only when this is high.
- resync  in  1  synchronous force-to-HUNT; has priority over bit_valid.
- sync_state  out  2  00 HUNT, 01 VERIFY, 10 LOCKED.
- locked  out  1  high when sync_state is LOCKED.
- frame_start  out  1  one-cycle pulse on each accepted preamble.
- miss_err  out  1  one-cycle pulse when an expected preamble window fails.
- payload_valid  out  1  one-cycle pulse per payload bit delivered.
- payload_bit  out  1  payload data, qualified by payload_valid.

## Operation
- Shift register sr[4:0] holds the last 5 accepted bits. It shifts only on a bit_valid sample. match = ({sr, x} == 6'b101010), evaluated on a valid sample.
- Position counter pos runs 0..FRAME_LEN+5 and advances on each valid sample outside HUNT:
  - pos < FRAME_LEN is the payload region.
  - pos FRAME_LEN..FRAME_LEN+5 is the preamble window.
  - At pos == FRAME_LEN+5 the window is evaluated, then pos returns to 0.
- HUNT:
  - match is checked on every valid bit. On the first match: frame_start=1, pos=0, good=1.
  - Next state is LOCKED if LOCK_CNT==1, otherwise VERIFY.
- VERIFY, window end:
  - On match: frame_start=1 and good++. If good reaches LOCK_CNT, go to LOCKED.
  - On miss: miss_err=1, go to HUNT.
- LOCKED, window end:
  - On match: frame_start=1, misses=0.
  - On miss: miss_err=1, misses++. If misses reaches UNLOCK_CNT, go to HUNT. Otherwise stay LOCKED and start the next frame at pos=0 (flywheel).
- Payload delivery: on a valid sample with state LOCKED and pos < FRAME_LEN, payload_valid=1 and payload_bit=x.
- Bits in the payload region are never checked against the preamble, so a false 101010 inside the payload is ignored.
- Entering HUNT from any cause clears pos, good and misses. sr keeps its contents, except on resync or reset.
- resync: next state HUNT, sr, pos, good and misses cleared, all pulses 0. A bit_valid sample in the same cycle is discarded.
- bit_valid low: no state, counter or sr change; all pulse outputs 0.

## Timing
- All outputs are registered. Each response appears in the cycle after the clk edge that samples the qualifying bit. Latency is 1 cycle.
- Pulse outputs are high for exactly one cycle and low otherwise.
- Reset (rst low) is asynchronous and immediate: sync_state=00, locked=0, frame_start=0, miss_err=0, payload_valid=0, payload_bit=0, sr=0, pos=0, good=0, misses=0. Reset asserted mid-frame abandons the frame. No pulse is emitted on reset release.
- A state transition and its frame_start/miss_err pulse become visible in the same cycle.
- Back-to-back valid bits are sustained at one bit per clock; there is no throughput limit.
- Counter widths: pos is $clog2(FRAME_LEN+6) bits; good and misses saturate at LOCK_CNT and UNLOCK_CNT.

## Test plan
Bench parameters: FRAME_LEN=4, LOCK_CNT=2, UNLOCK_CNT=2.
1. Reset: drive rst low mid-frame while LOCKED → in the same cycle all outputs are 0 and sync_state=00. After release, x idles at 0 → no frame_start pulse.
2. Acquire: feed 101010 1100 101010 0110 continuously → sync_state 01 after the 6th bit, 10 after the 16th bit, frame_start pulses at both points. The payload 0110 then emits 4 payload_valid pulses carrying 0,1,1,0.
3. Flywheel: while LOCKED, feed window 101011 → one miss_err pulse, locked stays 1, the next 4 payload bits are still emitted. A following good window gives frame_start and resets misses.
4. Loss of lock: feed two consecutive bad windows (000000, 111111) → miss_err twice, sync_state 00 in the cycle after the second window's last bit, payload_valid stays 0 afterwards.
5. Gaps: insert 3 idle cycles with bit_valid=0 and x toggling between every bit of scenario 2 → identical output sequence, only stretched in time.
6. resync and false preamble: assert resync together with bit_valid while LOCKED → sync_state 00 and that bit is dropped. Separately, while LOCKED, payload 1010 followed by the preamble → no extra frame_start.
